md_sequencer: RTL

Multiply/divide sequencer for the five-stage MIPS core. It owns the HI/LO registers. It accepts mult/multu/div/divu/mthi/mtlo from E stage and models the fixed 5-cycle (mult) and 10-cycle (div) occupancy. It serves mfhi/mflo reads and raises the stall request that holds a D-stage HI/LO instruction while the unit is occupied. It sits beside the E-stage ALU; the hazard/stall controller consumes `md_stall` and `md_busy`.

---
 rtl/md_sequencer_pkg.sv | 27 ++
 rtl/md_compute.sv | 41 ++++
 rtl/md_sequencer.sv | 98 +++++++++
 3 files changed

// File: rtl/md_sequencer_pkg.sv
// rtl/md_sequencer_pkg.sv - HI/LO op codes, cycle-count defaults and FSM states
package md_sequencer_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MFHI  = 3'd6,
        MD_MFLO  = 3'd7
    } md_op_e;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_compute.sv
// rtl/md_compute.sv - combinational 32x32 multiply / divide producing {hi,lo}
module md_compute
    import md_sequencer_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [63:0] result,
    output logic        div0
);

    logic signed [63:0] rs_sx;
    logic signed [63:0] rt_sx;
    logic        [63:0] rs_zx;
    logic        [63:0] rt_zx;

    // Widening to 64 bits keeps -2^31 / -1 representable instead of overflowing.
    assign rs_sx = {{32{rs[31]}}, rs};
    assign rt_sx = {{32{rt[31]}}, rt};
    assign rs_zx = {32'd0, rs};
    assign rt_zx = {32'd0, rt};

    always_comb begin
        result = '0;
        div0   = 1'b0;
        case (op)
            MD_MULT:  result = rs_sx * rt_sx;
            MD_MULTU: result = rs_zx * rt_zx;
            MD_DIV: begin
                if (rt == 32'd0) div0 = 1'b1;
                else result = {32'(rs_sx % rt_sx), 32'(rs_sx / rt_sx)};
            end
            MD_DIVU: begin
                if (rt == 32'd0) div0 = 1'b1;
                else result = {32'(rs_zx % rt_zx), 32'(rs_zx / rt_zx)};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - HI/LO owner with fixed-latency mult/div occupancy and stall
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_start,
    input  logic [2:0]  e_op,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        cancel,
    input  logic        d_is_md,
    output logic        md_busy,
    output logic [3:0]  md_remain,
    output logic        md_stall,
    output logic [31:0] md_rdata
);

    md_state_e   state;
    logic [3:0]  count;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_div0;
    logic        accept;
    logic [63:0] result;
    logic        div0;

    md_compute u_compute (
        .op     (e_op),
        .rs     (e_rs),
        .rt     (e_rt),
        .result (result),
        .div0   (div0)
    );

    assign accept = e_start & ~cancel;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            count     <= 4'd0;
            hi        <= 32'd0;
            lo        <= 32'd0;
            pend_hi   <= 32'd0;
            pend_lo   <= 32'd0;
            pend_div0 <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_muldiv(e_op)) begin
                            pend_hi   <= result[63:32];
                            pend_lo   <= result[31:0];
                            pend_div0 <= div0;
                            count     <= (e_op == MD_MULT || e_op == MD_MULTU) ?
                                         4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                            state     <= ST_BUSY;
                        end else if (e_op == MD_MTHI) begin
                            hi <= e_rs;
                        end else if (e_op == MD_MTLO) begin
                            lo <= e_rs;
                        end
                    end
                end
                ST_BUSY: begin
                    // Ops arriving while busy are ignored; the stall should keep them out.
                    if (count == 4'd1) begin
                        count <= 4'd0;
                        state <= ST_IDLE;
                        if (!pend_div0) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign md_busy   = (state == ST_BUSY);
    assign md_remain = count;
    assign md_stall  = d_is_md & (md_busy | (e_start & is_muldiv(e_op)));

    always_comb begin
        md_rdata = 32'd0;
        if (e_start && e_op == MD_MFHI) md_rdata = hi;
        else if (e_start && e_op == MD_MFLO) md_rdata = lo;
    end

endmodule
